// File: rtl/reset_sequencer_if.sv
// Sequencer-facing bundle: soft-reset request in, ordered active-low resets and DONE out.
// Build option RST_SEQ_PLL_LOCK_EN adds the LOCKED input from the clock generator.
interface reset_sequencer_if #(
  parameter int NUM_OUT = 4
);
  logic               SW_RST_REQ;
  logic [NUM_OUT-1:0] OUT_RST_N;
  logic               DONE;
`ifdef RST_SEQ_PLL_LOCK_EN
  logic               LOCKED;

  modport master (input SW_RST_REQ, input LOCKED, output OUT_RST_N, output DONE);
  modport slave  (output SW_RST_REQ, output LOCKED, input OUT_RST_N, input DONE);
`else
  modport master (input SW_RST_REQ, output OUT_RST_N, output DONE);
  modport slave  (output SW_RST_REQ, input OUT_RST_N, input DONE);
`endif
endinterface

// File: rtl/reset_sequencer.sv
// Ordered reset release: bit k rises HOLD_CYCLES + k*GAP_CYCLES edges after the last request, DONE one edge later.
// Build option RST_SEQ_PLL_LOCK_EN gates the sequence on a two-flop synchronised LOCKED input.
module reset_sequencer #(
  parameter int NUM_OUT     = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int CNT_W       = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  reset_sequencer_if.master    bus
);

  localparam int IDX_W = $clog2(NUM_OUT + 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] ONE       = NUM_OUT'(1);

  typedef enum logic [1:0] {ST_HOLD, ST_RELEASE, ST_RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic [NUM_OUT-1:0] out_q;
  logic               done_q;
  logic               lock_ok;
  logic               req;

`ifdef RST_SEQ_PLL_LOCK_EN
  logic [1:0] lock_sync;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lock_sync <= 2'b00;
    end else begin
      lock_sync <= {lock_sync[0], bus.LOCKED};
    end
  end

  assign lock_ok = lock_sync[1];
`else
  assign lock_ok = 1'b1;
`endif

  // Lost lock behaves like a held request: in HOLD it just pins cnt at 0.
  assign req = bus.SW_RST_REQ | ~lock_ok;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= ST_HOLD;
      cnt    <= '0;
      idx    <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
    end else if (req) begin
      state  <= ST_HOLD;
      cnt    <= '0;
      idx    <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            out_q <= ONE;
            cnt   <= '0;
            idx   <= IDX_W'(1);
            state <= (NUM_OUT == 1) ? ST_RUN : ST_RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt == GAP_LAST) begin
            // Bits release strictly in index order, so shifting in a one sets bit idx.
            out_q <= (out_q << 1) | ONE;
            cnt   <= '0;
            idx   <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              state <= ST_RUN;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          done_q <= 1'b1;
        end
        default: begin
          state <= ST_HOLD;
        end
      endcase
    end
  end

  assign bus.OUT_RST_N = out_q;
  assign bus.DONE      = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: release-time model plus literal pins, default and single-output builds.
module tb_reset_sequencer;

  logic CLK;
  logic RST_N;
  logic sw_rst_req;
  logic cmp_en;

  int n_checks;
  int n_err;
  int e;  // edges since reset release
  int m;  // last edge with a request (0 right after reset)

  reset_sequencer_if #(.NUM_OUT(4)) bus_a ();
  reset_sequencer_if #(.NUM_OUT(1)) bus_b ();

  assign bus_a.SW_RST_REQ = sw_rst_req;
  assign bus_b.SW_RST_REQ = sw_rst_req;

  reset_sequencer #(.NUM_OUT(4), .HOLD_CYCLES(16), .GAP_CYCLES(8), .CNT_W(16)) u_a (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus_a)
  );

  reset_sequencer #(.NUM_OUT(1), .HOLD_CYCLES(1), .GAP_CYCLES(8), .CNT_W(16)) u_b (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      e = 0;
      m = 0;
    end else begin
      e = e + 1;
      if (sw_rst_req) m = e;
    end
  end

  function automatic logic [15:0] exp_bits(int ee, int mm, int n, int h, int g);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k] = (ee >= mm + h + k * g);
    return r;
  endfunction

  function automatic logic [15:0] exp_done(int ee, int mm, int n, int h, int g);
    return {15'b0, (ee >= mm + h + (n - 1) * g + 1)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, e, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("model_a_out",  {12'b0, bus_a.OUT_RST_N}, exp_bits(e, m, 4, 16, 8));
      check("model_a_done", {15'b0, bus_a.DONE},      exp_done(e, m, 4, 16, 8));
      check("model_b_out",  {15'b0, bus_b.OUT_RST_N}, exp_bits(e, m, 1, 1, 8));
      check("model_b_done", {15'b0, bus_b.DONE},      exp_done(e, m, 1, 1, 8));
    end
  end

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (e < target && guard < 1000) begin
      @(posedge CLK);
      @(negedge CLK);
      guard++;
    end
    if (e != target) begin
      n_checks++;
      n_err++;
      $display("FAIL run_to: reached edge %0d, wanted %0d", e, target);
    end
  endtask

  task automatic restart();
    @(negedge CLK);
    #2 RST_N = 1'b0;
    @(negedge CLK);
    #2 RST_N = 1'b1;
  endtask

  initial begin
    RST_N      = 1'b0;
    sw_rst_req = 1'b0;
    cmp_en     = 1'b0;
    n_checks   = 0;
    n_err      = 0;
    @(posedge CLK);
    cmp_en = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_out",  {12'b0, bus_a.OUT_RST_N}, 16'h0000);
    check("reset_done", {15'b0, bus_a.DONE},      16'h0000);
    RST_N = 1'b1;

    // Power-on sequence
    run_to(1);
    check("b_out_e1",  {15'b0, bus_b.OUT_RST_N}, 16'h0001);
    check("b_done_e1", {15'b0, bus_b.DONE},      16'h0000);
    run_to(2);
    check("b_done_e2", {15'b0, bus_b.DONE},      16'h0001);
    run_to(15);
    check("po_e15", {12'b0, bus_a.OUT_RST_N}, 16'h0000);
    run_to(16);
    check("po_e16", {12'b0, bus_a.OUT_RST_N}, 16'h0001);
    run_to(24);
    check("po_e24", {12'b0, bus_a.OUT_RST_N}, 16'h0003);
    run_to(32);
    check("po_e32", {12'b0, bus_a.OUT_RST_N}, 16'h0007);
    run_to(40);
    check("po_e40",      {12'b0, bus_a.OUT_RST_N}, 16'h000f);
    check("po_done_e40", {15'b0, bus_a.DONE},      16'h0000);
    run_to(41);
    check("po_done_e41", {15'b0, bus_a.DONE},      16'h0001);

    // Single-edge soft request while running
    run_to(99);
    sw_rst_req = 1'b1;
    run_to(100);
    sw_rst_req = 1'b0;
    check("sw_e100_out",  {12'b0, bus_a.OUT_RST_N}, 16'h0000);
    check("sw_e100_done", {15'b0, bus_a.DONE},      16'h0000);
    check("sw_b_e100",    {15'b0, bus_b.OUT_RST_N}, 16'h0000);
    run_to(101);
    check("sw_b_e101",    {15'b0, bus_b.OUT_RST_N}, 16'h0001);
    run_to(115);
    check("sw_e115", {12'b0, bus_a.OUT_RST_N}, 16'h0000);
    run_to(116);
    check("sw_e116", {12'b0, bus_a.OUT_RST_N}, 16'h0001);
    run_to(140);
    check("sw_done_e140", {15'b0, bus_a.DONE}, 16'h0000);
    run_to(141);
    check("sw_done_e141", {15'b0, bus_a.DONE}, 16'h0001);
    run_to(150);

    // Held request during RELEASE aborts and re-asserts released bits
    restart();
    run_to(19);
    check("ab_e19", {12'b0, bus_a.OUT_RST_N}, 16'h0001);
    sw_rst_req = 1'b1;
    run_to(20);
    check("ab_e20", {12'b0, bus_a.OUT_RST_N}, 16'h0000);
    run_to(25);
    sw_rst_req = 1'b0;
    run_to(40);
    check("ab_e40", {12'b0, bus_a.OUT_RST_N}, 16'h0000);
    run_to(41);
    check("ab_e41", {12'b0, bus_a.OUT_RST_N}, 16'h0001);
    run_to(49);
    check("ab_e49", {12'b0, bus_a.OUT_RST_N}, 16'h0003);
    run_to(57);
    check("ab_e57", {12'b0, bus_a.OUT_RST_N}, 16'h0007);
    run_to(65);
    check("ab_e65",      {12'b0, bus_a.OUT_RST_N}, 16'h000f);
    check("ab_done_e65", {15'b0, bus_a.DONE},      16'h0000);
    run_to(66);
    check("ab_done_e66", {15'b0, bus_a.DONE},      16'h0001);
    run_to(70);

    // Asynchronous reset pulse between edges 30 and 31
    restart();
    run_to(29);
    @(posedge CLK);
    #1 check("ar_e30", {12'b0, bus_a.OUT_RST_N}, 16'h0003);
    #1 RST_N = 1'b0;
    #1 check("ar_async_out",  {12'b0, bus_a.OUT_RST_N}, 16'h0000);
    check("ar_async_done", {15'b0, bus_a.DONE}, 16'h0000);
    check("ar_async_b",    {15'b0, bus_b.OUT_RST_N}, 16'h0000);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    run_to(16);
    check("ar_e16", {12'b0, bus_a.OUT_RST_N}, 16'h0001);
    run_to(41);
    check("ar_done_e41", {15'b0, bus_a.DONE}, 16'h0001);
    run_to(45);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
